// File: rtl/bg_frame_reader.sv
// Streams one background frame of RGB565 words from SRAM in raster order and presents
// each pixel, expanded to 10-bit RGB, on a valid/ready port behind a 4-entry FIFO.
module bg_frame_reader #(
    parameter int          H_ACT     = 640,
    parameter int          V_ACT     = 480,
    parameter logic [19:0] BASE_ADDR = 20'h00000,
    parameter int          RD_LAT    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [9:0]  o_r,
    output logic [9:0]  o_g,
    output logic [9:0]  o_b,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_sram_rd,
    output logic        o_sram_wr,
    output logic [19:0] o_sram_addr,
    input  logic [15:0] i_sram_dq
);

    localparam int             NPIX   = H_ACT * V_ACT;
    localparam int             CW     = $clog2(NPIX + 1);
    localparam logic [CW-1:0]  NPIX_C = CW'(NPIX);
    localparam logic [10:0]    X_MAX  = 11'(H_ACT - 1);
    localparam logic [10:0]    Y_MAX  = 11'(V_ACT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [19:0]        addr_q, addr_d;
    logic [CW-1:0]      rd_cnt_q, rd_cnt_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic [2:0]         inflight_q, inflight_d;
    logic [2:0]         count_q, count_d;
    logic [1:0]         wptr_q, wptr_d;
    logic [1:0]         rptr_q, rptr_d;
    logic [15:0]        mem_q [4];
    logic [10:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;

    logic               pop_s;
    logic               push_s;
    logic               credit_s;
    logic               issue_s;
    logic               busy_s;
    logic [15:0]        head_s;

    // FIFO handshake and read credit; a pop in this cycle frees a slot immediately so
    // the fetch loop keeps 1 pixel/cycle for RD_LAT up to 3.
    always_comb begin
        pop_s    = (count_q != 3'd0) && i_ready;
        push_s   = vld_q[RD_LAT-1] && ((count_q != 3'd4) || pop_s);
        credit_s = ({1'b0, count_q} + {1'b0, inflight_q}) < (4'd4 + {3'd0, pop_s});
        head_s   = mem_q[rptr_q];
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = ST_FETCH;
                else         state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (rd_cnt_q == NPIX_C) state_d = ST_DRAIN;
                else                    state_d = ST_FETCH;
            end
            ST_DRAIN: begin
                if ((inflight_q == 3'd0) &&
                    ((count_q == 3'd0) || ((count_q == 3'd1) && pop_s))) state_d = ST_IDLE;
                else                                                      state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the read decision is made one cycle ahead of o_sram_rd
    always_comb begin
        issue_s = 1'b0;
        busy_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue_s = i_start;
                busy_s  = 1'b0;
            end
            ST_FETCH: begin
                issue_s = (rd_cnt_q != NPIX_C) && credit_s;
                busy_s  = 1'b1;
            end
            ST_DRAIN: begin
                issue_s = 1'b0;
                busy_s  = 1'b1;
            end
            default: begin
                issue_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Datapath next values: address/read count, latency tracker, FIFO pointers, x/y
    always_comb begin
        addr_d   = addr_q;
        rd_cnt_d = rd_cnt_q;
        if (issue_s) begin
            if (state_q == ST_IDLE) begin
                addr_d   = BASE_ADDR;
                rd_cnt_d = CW'(1);
            end else begin
                addr_d   = addr_q + 20'd1;
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end else begin
            addr_d   = addr_q;
            rd_cnt_d = rd_cnt_q;
        end

        vld_d    = '0;
        vld_d[0] = issue_s;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        inflight_d = inflight_q + {2'd0, issue_s} - {2'd0, vld_q[RD_LAT-1]};
        count_d    = count_q + {2'd0, push_s} - {2'd0, pop_s};
        wptr_d     = push_s ? (wptr_q + 2'd1) : wptr_q;
        rptr_d     = pop_s  ? (rptr_q + 2'd1) : rptr_q;

        x_d = x_q;
        y_d = y_q;
        if (pop_s) begin
            if (x_q == X_MAX) begin
                x_d = 11'd0;
                if (y_q == Y_MAX) y_d = 11'd0;
                else              y_d = y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Datapath registers; clearing vld_q on reset drops any SRAM data still in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= BASE_ADDR;
            rd_cnt_q   <= '0;
            vld_q      <= '0;
            inflight_q <= 3'd0;
            count_q    <= 3'd0;
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            x_q        <= 11'd0;
            y_q        <= 11'd0;
        end else begin
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    // FIFO storage; contents are qualified by count_q so no reset is needed
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= i_sram_dq;
        end
    end

    assign o_valid     = (count_q != 3'd0);
    assign o_r         = {head_s[15:11], head_s[15:11]};
    assign o_g         = {head_s[10:5], head_s[10:7]};
    assign o_b         = {head_s[4:0], head_s[4:0]};
    assign o_x         = x_q;
    assign o_y         = y_q;
    assign o_last      = o_valid && (x_q == X_MAX) && (y_q == Y_MAX);
    assign o_busy      = busy_s;
    assign o_sram_rd   = vld_q[0];
    assign o_sram_wr   = 1'b0;
    assign o_sram_addr = addr_q;

endmodule

// File: tb/tb_bg_frame_reader.sv
// Scoreboard bench for bg_frame_reader on a reduced 8x4 frame with an SRAM model
// whose data appears RD_LAT edges after the read is issued.
module tb_bg_frame_reader;

    localparam int          H    = 8;
    localparam int          V    = 4;
    localparam int          N    = H * V;
    localparam logic [19:0] BASE = 20'h00100;
    localparam int          LAT  = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
        logic        last;
    } pix_t;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_ready;
    logic        o_valid, o_last, o_busy, o_sram_rd, o_sram_wr;
    logic [9:0]  o_r, o_g, o_b;
    logic [10:0] o_x, o_y;
    logic [19:0] o_sram_addr;
    logic [15:0] sram_dq = 16'hDEAD;

    pix_t        exp_q[$];
    logic [19:0] addr_exp_q[$];

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  acc   = 0;
    int  iss   = 0;
    logic req_idle = 1'b0, req_timeout = 1'b0, req_drain = 1'b0, mode_full = 1'b0;

    bg_frame_reader #(.H_ACT(H), .V_ACT(V), .BASE_ADDR(BASE), .RD_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_ready(i_ready),
        .o_valid(o_valid), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_x(o_x), .o_y(o_y),
        .o_last(o_last), .o_busy(o_busy), .o_sram_rd(o_sram_rd), .o_sram_wr(o_sram_wr),
        .o_sram_addr(o_sram_addr), .i_sram_dq(sram_dq)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [19:0] k;
        logic [19:0] p;
        k = a - BASE;
        p = k * 20'd2111;
        case (k)
            20'd1:   return 16'hF800;
            20'd2:   return 16'h07E0;
            20'd3:   return 16'h001F;
            default: return p[15:0];
        endcase
    endfunction

    // SRAM model: one register stage so data is captured LAT edges after issue
    always @(posedge clk) begin
        if (o_sram_rd) sram_dq <= sram_word(o_sram_addr);
        else           sram_dq <= 16'hDEAD;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted pixel and checks protocol rules
    logic        arm_rd = 1'b0, arm_vld = 1'b0, busy_chk = 1'b0, prev_stall = 1'b0;
    int          t0 = 0, first_cyc = 0;
    logic [52:0] prev_vec = '0;
    always @(negedge clk) begin
        pix_t        e;
        logic [52:0] vec;
        vec = {o_x, o_y, o_r, o_g, o_b, o_last};
        if (i_rst) begin
            prev_stall = 1'b0; arm_rd = 1'b0; arm_vld = 1'b0; busy_chk = 1'b0;
            iss = 0; acc = 0;
        end else begin
            if (req_idle)
                check("idle_state", {o_valid, o_busy, o_sram_rd, o_sram_wr, o_last, o_sram_addr, o_x, o_y},
                      {5'b00000, BASE, 11'd0, 11'd0});
            if (req_timeout) check("timeout", 64'd1, 64'd0);
            if (req_drain) begin
                check("pix_left", 64'(exp_q.size()), 64'd0);
                check("addr_left", 64'(addr_exp_q.size()), 64'd0);
            end
            if (busy_chk) begin
                check("busy_after_last", {63'd0, o_busy}, 64'd0);
                busy_chk = 1'b0;
            end
            if (i_start && !o_busy) begin
                t0 = cyc; arm_rd = 1'b1; arm_vld = 1'b1; iss = 0; acc = 0;
            end
            if (o_sram_rd) begin
                iss++;
                if (arm_rd) begin
                    check("rd_latency", 64'(cyc - t0), 64'd1);
                    arm_rd = 1'b0;
                end
                if (addr_exp_q.size() == 0) check("extra_read", {44'd0, o_sram_addr}, 64'hFFFFF);
                else                        check("rd_addr", {44'd0, o_sram_addr}, {44'd0, addr_exp_q.pop_front()});
                check("outstanding_le4", {63'd0, (iss - acc) <= 4}, 64'd1);
            end
            if (o_valid) begin
                if (arm_vld) begin
                    check("valid_latency", 64'(cyc - t0), 64'd3);
                    arm_vld = 1'b0;
                end
                if (prev_stall) check("stall_stable", {11'd0, vec}, {11'd0, prev_vec});
                if (i_ready) begin
                    acc++;
                    if (acc == 1) first_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", {11'd0, vec}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {11'd0, vec}, {11'd0, e});
                        if (e.last) begin
                            busy_chk = 1'b1;
                            if (mode_full) check("throughput", 64'(cyc - first_cyc), 64'(N - 1));
                        end
                    end
                end
                prev_stall = !i_ready;
                prev_vec   = vec;
            end else begin
                if (prev_stall) check("valid_dropped", 64'd0, 64'd1);
                if (o_busy) check("last_without_valid", {63'd0, o_last}, 64'd0);
                prev_stall = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_timeout();
        req_timeout = 1'b1; tick(); req_timeout = 1'b0;
    endtask

    task automatic start_frame();
        pix_t        e;
        logic [15:0] w;
        for (int k = 0; k < N; k++) begin
            w      = sram_word(BASE + 20'(k));
            e.x    = 11'(k % H);
            e.y    = 11'(k / H);
            e.r    = {w[15:11], w[15:11]};
            e.g    = {w[10:5], w[10:7]};
            e.b    = {w[4:0], w[4:0]};
            e.last = (k == N - 1);
            case (k)
                1:       begin e.r = 10'h3FF; e.g = 10'h000; e.b = 10'h000; end
                2:       begin e.r = 10'h000; e.g = 10'h3FF; e.b = 10'h000; end
                3:       begin e.r = 10'h000; e.g = 10'h000; e.b = 10'h3FF; end
                4:       begin e.r = 10'h084; e.g = 10'h071; e.b = 10'h39C; end
                default: begin end
            endcase
            exp_q.push_back(e);
            addr_exp_q.push_back(BASE + 20'(k));
        end
        i_start = 1'b1; tick(); i_start = 1'b0;
    endtask

    task automatic wait_done(input bit random_ready);
        int n;
        n = 0;
        tick(); tick();
        while (o_busy && n < 2000) begin
            if (random_ready) i_ready = ($urandom_range(0, 9) < 3);
            tick();
            n++;
        end
        i_ready = 1'b1;
        if (n >= 2000) pulse_timeout();
        tick(); tick();
        req_drain = 1'b1; tick(); req_drain = 1'b0;
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        req_idle = 1'b1; tick(); req_idle = 1'b0;

        // full frame, ready held high
        mode_full = 1'b1;
        start_frame();
        wait_done(1'b0);

        // start pulsed again while fetching must be ignored
        start_frame();
        repeat (3) tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        wait_done(1'b0);

        // random backpressure
        mode_full = 1'b0;
        start_frame();
        wait_done(1'b1);

        // reset in the middle of a frame, then restart from (0,0)
        mode_full = 1'b1;
        start_frame();
        n = 0;
        while (acc < 10 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) pulse_timeout();
        i_rst = 1'b1;
        exp_q.delete();
        addr_exp_q.delete();
        tick();
        i_rst = 1'b0;
        req_idle = 1'b1; tick(); req_idle = 1'b0;
        start_frame();
        wait_done(1'b0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
